alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, giving the ALU settle wait in clocks; legal range 1..15.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_a, req0_b, req1_a, req1_b  input  32 each  operands.
REQ-006 req0_op, req1_op  input  3 each  ALU command: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
REQ-007 req0_ready, req1_ready  output  1 each  the operation is accepted this cycle.
REQ-008 alu_a, alu_b  output  32 each  registered operands driven to the shared ALU.
REQ-009 alu_sel  output  3  registered command driven to the shared ALU.
REQ-010 alu_out  input  32; alu_carry, alu_overflow, alu_zero  input  1 each  ALU results.
REQ-011 rsp0_valid, rsp1_valid  output  1 each  one-cycle response pulse to requester N.
REQ-012 rsp_data  output  32; rsp_carry, rsp_overflow, rsp_zero  output  1 each  captured result, shared by both requesters.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SETTLE and DONE.
REQ-015 In IDLE with at least one valid, the block SHALL grant one requester and raise only that requester's ready, combinationally, in the same cycle.
REQ-016 On the grant edge the block SHALL register the winner's a, b and op into alu_a, alu_b and alu_sel, load the counter with SETTLE_CYCLES-1, record the owner, and go to SETTLE.
REQ-017 In SETTLE the block SHALL hold alu_a, alu_b and alu_sel stable and decrement the counter every cycle.
REQ-018 In SETTLE with counter==0, the block SHALL capture alu_out and all three flags into the rsp_* registers and go to DONE.
REQ-019 In DONE the block SHALL assert rsp<owner>_valid for exactly one cycle and return to IDLE.
REQ-020 Latency: an accept in cycle T SHALL give rsp_valid in cycle T+SETTLE_CYCLES+1; throughput SHALL be one operation per SETTLE_CYCLES+2 cycles.
REQ-021 Both ready outputs SHALL be 0 outside IDLE; a valid raised then SHALL wait, with no loss and no grant.
REQ-022 The rsp_* data SHALL hold its value until the next capture.
REQ-023 A valid dropped before grant SHALL be ignored; the block SHALL NOT track requests between cycles.
REQ-024 rsp0_valid and rsp1_valid SHALL never be high in the same cycle.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, counter 0, owner 0, and the round-robin pointer to "last granted = 1".
REQ-026 rst_n low SHALL force alu_a, alu_b, alu_sel, rsp_data and all rsp flags to 0, and both rsp_valid outputs to 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no response pulse; the requester SHALL re-issue it.

Configuration
REQ-028 With macro ALU_ARBITER_RR_EN defined, a simultaneous request SHALL go to the requester not granted last, and every grant SHALL update the pointer.
REQ-029 Without ALU_ARBITER_RR_EN, a simultaneous request SHALL always go to requester 0 (fixed priority), and no pointer register SHALL exist.

Verification
REQ-030 ADD, SETTLE_CYCLES=4: req0 a=0x7FFFFFFF b=0x00000001 -> accept cycle T, then rsp0_valid at T+5 with rsp_data=0x80000000, carry 0, overflow 1, zero 0.
REQ-031 SUB: req1 a=5 b=5 op=1 -> rsp1_valid with rsp_data=0, zero 1, carry 1, overflow 0; rsp0_valid stays 0.
REQ-032 RR, macro defined: both valid continuously with op=2 (XOR) -> grants go 0,1,0,1; the ready pulses are 6 cycles apart. Macro undefined: all grants go to req0 while req0_valid is held.
REQ-033 Busy hold-off: raise req1_valid while in SETTLE -> req1_ready stays 0 until IDLE, then is granted; alu_a/alu_b/alu_sel stay unchanged during SETTLE.
REQ-034 Reset mid-op: assert rst_n low during SETTLE -> busy=0 and all outputs are 0 immediately, with no rsp pulse after release.
REQ-035 SETTLE_CYCLES=1: AND a=0xF0F0F0F0 b=0xFF00FF00 -> rsp at T+2 with rsp_data=0xF000F000, zero 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared multi-cycle ALU: grant, wait SETTLE_CYCLES, capture, pulse.
// Define ALU_ARBITER_RR_EN for round-robin grants; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int SETTLE_CYCLES = 4   // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req0_op,
    input  logic [2:0]  req1_op,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_carry,
    output logic        rsp_overflow,
    output logic        rsp_zero,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic        owner_reg, owner_next;
    logic [31:0] alu_a_reg, alu_a_next;
    logic [31:0] alu_b_reg, alu_b_next;
    logic [2:0]  alu_sel_reg, alu_sel_next;
    logic [31:0] rsp_data_reg, rsp_data_next;
    logic        rsp_carry_reg, rsp_carry_next;
    logic        rsp_overflow_reg, rsp_overflow_next;
    logic        rsp_zero_reg, rsp_zero_next;

    logic [1:0]  req_valid;
    logic [1:0]  ready_vec;
    logic [1:0]  rsp_vec;
    logic        grant_id;

    assign req_valid = {req1_valid, req0_valid};

`ifdef ALU_ARBITER_RR_EN
    logic last_reg, last_next;
    // On contention the requester that did not win last time goes first.
    assign grant_id = (req0_valid && req1_valid) ? ~last_reg : req1_valid;
`else
    assign grant_id = ~req0_valid & req1_valid;
`endif

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign ready_vec[gi] = (state_reg == IDLE) && req_valid[gi] && (grant_id == 1'(gi));
        assign rsp_vec[gi]   = (state_reg == DONE) && (owner_reg == 1'(gi));
    end

    always_comb begin
        state_next        = state_reg;
        count_next        = count_reg;
        owner_next        = owner_reg;
        alu_a_next        = alu_a_reg;
        alu_b_next        = alu_b_reg;
        alu_sel_next      = alu_sel_reg;
        rsp_data_next     = rsp_data_reg;
        rsp_carry_next    = rsp_carry_reg;
        rsp_overflow_next = rsp_overflow_reg;
        rsp_zero_next     = rsp_zero_reg;
`ifdef ALU_ARBITER_RR_EN
        last_next         = last_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    state_next   = SETTLE;
                    count_next   = CNT_LOAD;
                    owner_next   = grant_id;
                    alu_a_next   = grant_id ? req1_a  : req0_a;
                    alu_b_next   = grant_id ? req1_b  : req0_b;
                    alu_sel_next = grant_id ? req1_op : req0_op;
`ifdef ALU_ARBITER_RR_EN
                    last_next    = grant_id;
`endif
                end
            end
            SETTLE: begin
                if (count_reg == 4'd0) begin
                    state_next        = DONE;
                    rsp_data_next     = alu_out;
                    rsp_carry_next    = alu_carry;
                    rsp_overflow_next = alu_overflow;
                    rsp_zero_next     = alu_zero;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            count_reg        <= 4'd0;
            owner_reg        <= 1'b0;
            alu_a_reg        <= 32'd0;
            alu_b_reg        <= 32'd0;
            alu_sel_reg      <= 3'd0;
            rsp_data_reg     <= 32'd0;
            rsp_carry_reg    <= 1'b0;
            rsp_overflow_reg <= 1'b0;
            rsp_zero_reg     <= 1'b0;
`ifdef ALU_ARBITER_RR_EN
            last_reg         <= 1'b1;
`endif
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            owner_reg        <= owner_next;
            alu_a_reg        <= alu_a_next;
            alu_b_reg        <= alu_b_next;
            alu_sel_reg      <= alu_sel_next;
            rsp_data_reg     <= rsp_data_next;
            rsp_carry_reg    <= rsp_carry_next;
            rsp_overflow_reg <= rsp_overflow_next;
            rsp_zero_reg     <= rsp_zero_next;
`ifdef ALU_ARBITER_RR_EN
            last_reg         <= last_next;
`endif
        end
    end

    assign req0_ready   = ready_vec[0];
    assign req1_ready   = ready_vec[1];
    assign rsp0_valid   = rsp_vec[0];
    assign rsp1_valid   = rsp_vec[1];
    assign alu_a        = alu_a_reg;
    assign alu_b        = alu_b_reg;
    assign alu_sel      = alu_sel_reg;
    assign rsp_data     = rsp_data_reg;
    assign rsp_carry    = rsp_carry_reg;
    assign rsp_overflow = rsp_overflow_reg;
    assign rsp_zero     = rsp_zero_reg;
    assign busy         = (state_reg != IDLE);

endmodule
